// File: rtl/xgriscv_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, operand signedness.
package xgriscv_mdu_pkg;

  typedef logic [2:0] mdu_op_t;

  localparam mdu_op_t MDU_MUL    = 3'd0;
  localparam mdu_op_t MDU_MULH   = 3'd1;
  localparam mdu_op_t MDU_MULHSU = 3'd2;
  localparam mdu_op_t MDU_MULHU  = 3'd3;
  localparam mdu_op_t MDU_DIV    = 3'd4;
  localparam mdu_op_t MDU_DIVU   = 3'd5;
  localparam mdu_op_t MDU_REM    = 3'd6;
  localparam mdu_op_t MDU_REMU   = 3'd7;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_CALC = 2'd1;
  localparam logic [1:0] MDU_FIX  = 2'd2;
  localparam logic [1:0] MDU_DONE = 2'd3;

  function automatic logic is_div_op(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic a_is_signed(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic b_is_signed(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/xgriscv_mdu_if.sv
// Request/response handshake bundle between the execute stage (master) and the MDU (slave).
interface xgriscv_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/xgriscv_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module xgriscv_mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-2:0] quo_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN+1:0] shifted;
  logic            fits;

  assign shifted = {rem_in, dvd_bit};
  assign fits    = shifted >= {2'b00, divisor};
  assign rem_out = fits ? (XLEN+1)'(shifted - {2'b00, divisor}) : shifted[XLEN:0];
  assign quo_out = {quo_in, fits};
endmodule

// File: rtl/xgriscv_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit, one bit per cycle, tagged valid/ready result.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier in CALC.
module xgriscv_mdu
  import xgriscv_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          reset,
  xgriscv_mdu_if.slave mdu
);
  localparam int CNT_W = $clog2(XLEN);

  logic [1:0]        state;
  logic [CNT_W-1:0]  counter;
  mdu_op_t           op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic              a_neg_q, b_neg_q;

  logic              accept, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, step_quo, quo, rmd, fix_res;
  logic [XLEN:0]     add_sum, step_rem;
  logic [2*XLEN-1:0] prod, fast_lo;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic signed [2*XLEN-1:0] fast_a, fast_b;
  // Operands kept raw; the latched sign bits act as the extension bit of an XLEN+1 multiplier.
  assign fast_a  = signed'({{XLEN{a_neg_q}}, opnd});
  assign fast_b  = signed'({{XLEN{b_neg_q}}, acc[XLEN-1:0]});
  assign fast_lo = fast_a * fast_b;
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_lo = '0;
`endif

  assign mdu.in_ready  = (state == MDU_IDLE) & ~mdu.flush;
  assign mdu.busy      = (state != MDU_IDLE);
  assign mdu.out_valid = (state == MDU_DONE);
  assign mdu.result    = result_q;
  assign mdu.out_tag   = tag_q;

  // Request decode: magnitudes and divide corner cases
  assign accept      = mdu.in_valid & mdu.in_ready;
  assign a_neg       = a_is_signed(mdu.op) & mdu.a[XLEN-1];
  assign b_neg       = b_is_signed(mdu.op) & mdu.b[XLEN-1];
  assign abs_a       = a_neg ? neg_x(mdu.a) : mdu.a;
  assign abs_b       = b_neg ? neg_x(mdu.b) : mdu.b;
  assign b_zero      = (mdu.b == '0);
  assign ovf         = ((mdu.op == MDU_DIV) || (mdu.op == MDU_REM)) &&
                       (mdu.a == {1'b1, {(XLEN-1){1'b0}}}) && (&mdu.b);
  assign special_res = b_zero ? (mdu.op[1] ? mdu.a : '1) : (mdu.op[1] ? '0 : mdu.a);

  // Iteration datapath
  assign add_sum = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd})
                          : {1'b0, acc[2*XLEN-1:XLEN]};

  xgriscv_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_in  (rem),
    .quo_in  (acc[XLEN-2:0]),
    .dvd_bit (acc[XLEN-1]),
    .divisor (opnd),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix and result select
  assign prod = (!FAST_MUL && (a_neg_q ^ b_neg_q)) ? neg_2x(acc) : acc;
  assign quo  = (a_neg_q ^ b_neg_q) ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rmd  = a_neg_q ? neg_x(rem[XLEN-1:0]) : rem[XLEN-1:0];

  always_comb begin
    fix_res = rmd;
    case (op_q)
      MDU_MUL:                         fix_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_res = quo;
      default:                         fix_res = rmd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= MDU_IDLE;
      counter  <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (mdu.flush) begin
      state <= MDU_IDLE;
    end else begin
      case (state)
        MDU_IDLE: if (accept) begin
          tag_q   <= mdu.in_tag;
          counter <= CNT_W'(XLEN-1);
          if (is_div_op(mdu.op) && (b_zero || ovf)) begin
            result_q <= special_res;
            state    <= MDU_DONE;
          end else begin
            state <= MDU_CALC;
          end
        end
        MDU_CALC: begin
          if ((FAST_MUL && !is_div_op(op_q)) || (counter == '0)) state <= MDU_FIX;
          else counter <= counter - CNT_W'(1);
        end
        MDU_FIX: begin
          result_q <= fix_res;
          state    <= MDU_DONE;
        end
        default: if (mdu.out_ready) state <= MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= mdu.op;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      rem     <= '0;
      if (is_div_op(mdu.op)) begin
        acc  <= {{XLEN{1'b0}}, abs_a};
        opnd <= abs_b;
      end else if (FAST_MUL) begin
        acc  <= {{XLEN{1'b0}}, mdu.b};
        opnd <= mdu.a;
      end else begin
        acc  <= {{XLEN{1'b0}}, abs_b};
        opnd <= abs_a;
      end
    end else if (state == MDU_CALC) begin
      if (is_div_op(op_q)) begin
        rem             <= step_rem;
        acc[XLEN-1:0]   <= step_quo;
      end else if (FAST_MUL) begin
        acc <= fast_lo;
      end else begin
        acc <= {add_sum, acc[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_mdu.sv
// Directed bench for xgriscv_mdu: reset, divide, multiply, divide corner cases,
// backpressure, flush, mid-operation reset and back-to-back requests.
module tb_xgriscv_mdu;
  import xgriscv_mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  xgriscv_mdu_if #(.XLEN(32), .TAG_W(5)) mdu_bus ();

  xgriscv_mdu #(.XLEN(32), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Present one request, wait (bounded) for the result, then complete the handshake.
  task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt,
                        output int lat);
    int n;
    mdu_bus.op = o; mdu_bus.a = x; mdu_bus.b = y; mdu_bus.in_tag = t;
    mdu_bus.in_valid = 1'b1; mdu_bus.out_ready = 1'b0;
    n = 0;
    while (!mdu_bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    mdu_bus.in_valid = 1'b0;
    lat = 1;
    while (!mdu_bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r  = mdu_bus.result;
    rt = mdu_bus.out_tag;
    mdu_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    mdu_bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    mdu_bus.flush = 1'b0; mdu_bus.in_valid = 1'b0; mdu_bus.out_ready = 1'b0;
    mdu_bus.op = MDU_MUL; mdu_bus.a = '0; mdu_bus.b = '0; mdu_bus.in_tag = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mdu_bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", mdu_bus.out_valid); end
    checks++;
    if (mdu_bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mdu_bus.busy); end
    checks++;
    if (mdu_bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", mdu_bus.result); end
    checks++;
    if (mdu_bus.out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", mdu_bus.out_tag); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mdu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", mdu_bus.in_ready); end
  endtask

  task automatic test_divide();
    mdu_op_t     ops [6] = '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM};
    logic [31:0] va  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] vb  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], 5'(i + 1), r, rt, lat);
      checks++;
      if (r !== exp[i]) begin errors++; $display("FAIL div[%0d]_result got %h want %h", i, r, exp[i]); end
      checks++;
      if (rt !== 5'(i + 1)) begin errors++; $display("FAIL div[%0d]_tag got %0d want %0d", i, rt, i + 1); end
      checks++;
      if (lat != DIV_LAT) begin errors++; $display("FAIL div[%0d]_latency got %0d want %0d", i, lat, DIV_LAT); end
    end
  endtask

  task automatic test_multiply();
    mdu_op_t     ops [8] = '{MDU_MULHU, MDU_MUL, MDU_MULHSU, MDU_MULH,
                             MDU_MUL, MDU_MULH, MDU_MUL, MDU_MULHU};
    logic [31:0] va  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd3, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] vb  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd4, 32'h80000000, 32'd2, 32'd2};
    logic [31:0] exp [8] = '{32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                             32'd12, 32'h40000000, 32'h00000000, 32'h00000001};
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], va[i], vb[i], 5'(i + 10), r, rt, lat);
      checks++;
      if (r !== exp[i]) begin errors++; $display("FAIL mul[%0d]_result got %h want %h", i, r, exp[i]); end
      checks++;
      if (rt !== 5'(i + 10)) begin errors++; $display("FAIL mul[%0d]_tag got %0d want %0d", i, rt, i + 10); end
      checks++;
      if (lat != MUL_LAT) begin errors++; $display("FAIL mul[%0d]_latency got %0d want %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div_special();
    mdu_op_t     ops [6] = '{MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM, MDU_DIV, MDU_REM};
    logic [31:0] va  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] vb  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], 5'(i + 20), r, rt, lat);
      checks++;
      if (r !== exp[i]) begin errors++; $display("FAIL special[%0d]_result got %h want %h", i, r, exp[i]); end
      checks++;
      if (rt !== 5'(i + 20)) begin errors++; $display("FAIL special[%0d]_tag got %0d want %0d", i, rt, i + 20); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL special[%0d]_latency got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    mdu_bus.op = MDU_DIVU; mdu_bus.a = 32'd100; mdu_bus.b = 32'd7; mdu_bus.in_tag = 5'd9;
    mdu_bus.in_valid = 1'b1; mdu_bus.out_ready = 1'b0;
    @(posedge clk); #1;
    mdu_bus.in_valid = 1'b0;
    n = 0;
    while (!mdu_bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mdu_bus.out_valid !== 1'b1 || mdu_bus.result !== 32'd14 || mdu_bus.out_tag !== 5'd9 ||
          mdu_bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got valid=%b result=%h tag=%0d in_ready=%b want 1/0000000e/9/0",
                 i, mdu_bus.out_valid, mdu_bus.result, mdu_bus.out_tag, mdu_bus.in_ready);
      end
      @(posedge clk); #1;
    end
    mdu_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    mdu_bus.out_ready = 1'b0;
    checks++;
    if (mdu_bus.out_valid !== 1'b0 || mdu_bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release got valid=%b in_ready=%b want 0/1", mdu_bus.out_valid, mdu_bus.in_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    logic        seen;
    mdu_bus.op = MDU_DIV; mdu_bus.a = 32'hFFFFFFF9; mdu_bus.b = 32'd2; mdu_bus.in_tag = 5'd3;
    mdu_bus.in_valid = 1'b1;
    @(posedge clk); #1;
    mdu_bus.in_valid = 1'b0;
    checks++;
    if (mdu_bus.busy !== 1'b1) begin errors++; $display("FAIL flush_accept_busy got %b want 1", mdu_bus.busy); end
    repeat (9) begin @(posedge clk); #1; end
    mdu_bus.flush = 1'b1;
    mdu_bus.op = MDU_DIVU; mdu_bus.a = 32'd100; mdu_bus.b = 32'd7; mdu_bus.in_tag = 5'd4;
    mdu_bus.in_valid = 1'b1;
    checks++;
    if (mdu_bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", mdu_bus.in_ready); end
    @(posedge clk); #1;
    mdu_bus.flush = 1'b0;
    mdu_bus.in_valid = 1'b0;
    checks++;
    if (mdu_bus.busy !== 1'b0 || mdu_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got busy=%b valid=%b want 0/0", mdu_bus.busy, mdu_bus.out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mdu_bus.out_valid || mdu_bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got activity=%b want 0", seen); end
    run_op(MDU_DIVU, 32'd100, 32'd7, 5'd4, r, rt, lat);
    checks++;
    if (r !== 32'd14 || rt !== 5'd4 || lat != DIV_LAT) begin
      errors++;
      $display("FAIL flush_replay got result=%h tag=%0d lat=%0d want 0000000e/4/%0d", r, rt, lat, DIV_LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    logic        seen;
    mdu_bus.op = MDU_DIV; mdu_bus.a = 32'd1000; mdu_bus.b = 32'd3; mdu_bus.in_tag = 5'd7;
    mdu_bus.in_valid = 1'b1;
    @(posedge clk); #1;
    mdu_bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (mdu_bus.out_valid !== 1'b0 || mdu_bus.busy !== 1'b0 || mdu_bus.in_ready !== 1'b1 ||
        mdu_bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b busy=%b in_ready=%b result=%h want 0/0/1/00000000",
               mdu_bus.out_valid, mdu_bus.busy, mdu_bus.in_ready, mdu_bus.result);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mdu_bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_discard got out_valid=%b want 0", seen); end
    run_op(MDU_MUL, 32'd3, 32'd4, 5'd12, r, rt, lat);
    checks++;
    if (r !== 32'd12 || rt !== 5'd12 || lat != MUL_LAT) begin
      errors++;
      $display("FAIL reset_mid_mul got result=%h tag=%0d lat=%0d want 0000000c/12/%0d", r, rt, lat, MUL_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [4:0]  rt;
    int          lat;
    run_op(MDU_REMU, 32'd100, 32'd7, 5'd30, r, rt, lat);
    checks++;
    if (r !== 32'd2 || rt !== 5'd30) begin
      errors++;
      $display("FAIL b2b_first got result=%h tag=%0d want 00000002/30", r, rt);
    end
    checks++;
    if (mdu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", mdu_bus.in_ready); end
    run_op(MDU_MULHU, 32'h00010000, 32'h00030000, 5'd31, r, rt, lat);
    checks++;
    if (r !== 32'd3 || rt !== 5'd31 || lat != MUL_LAT) begin
      errors++;
      $display("FAIL b2b_second got result=%h tag=%0d lat=%0d want 00000003/31/%0d", r, rt, lat, MUL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_multiply();
    test_div_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xgriscv_mdu.md
Name: xgriscv_mdu

Overview:
Parametrised multi-cycle multiply/divide unit implementing the RV32M/RV64M M-extension operations. It sits beside the combinational ALU in the execute stage. The unit takes operands through a valid/ready handshake, iterates one bit per cycle, and returns a tagged result through a second valid/ready handshake. The pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width (32 or 64)
TAG_W, 5, width of the destination tag carried alongside the operation (rd index)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  kill in-flight operation (branch mispredict/trap)
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  3  MDU op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
in_tag  input  TAG_W  destination tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
out_tag  output  TAG_W  tag of the result
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-low. With reset low at a rising edge: state=IDLE, out_valid=0, result=0, out_tag=0, counter=0, busy=0. Reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE) & ~flush. A request is accepted on in_valid & in_ready.
- IDLE -> CALC on accept. On accept, latch op, tag, operand magnitudes (abs per signedness of op), and result sign. Counter loads XLEN-1.
- Special cases skip CALC/FIX and go IDLE -> DONE, giving out_valid the cycle after accept:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV gives a; REM gives 0.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, XLEN+1-bit partial remainder.
  - Counter decrements. When counter==0, go to FIX.
- FIX, one cycle:
  - Negate the product/quotient when the result sign is negative.
  - Remainder takes the dividend's sign.
  - Select the low half (MUL) or high half (MULH*), or quotient/remainder.
  - Register result, then go to DONE.
- Normal latency: out_valid rises exactly XLEN+2 cycles after the accept edge (34 for XLEN=32).
- DONE: out_valid=1; result and out_tag stay stable until out_ready. On out_valid & out_ready, go to IDLE next cycle. A new accept is possible at the earliest one cycle after the handshake; there is no same-cycle turnaround.
- flush: from any state, go to IDLE next cycle with out_valid=0. A request presented in the flush cycle is not accepted. A flush coincident with an out_ready handshake counts as a completed handshake; the result is consumed.
- Arithmetic width rules:
  - MULHSU treats a as signed and b as unsigned.
  - All negation is two's complement within 2*XLEN bits (multiply) or XLEN bits (divide).
  - No X propagation into result when idle.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: multiply ops (0-3) use a single combinational XLEN x XLEN signed (XLEN+1-bit extended) multiplier in CALC. CALC lasts exactly 1 cycle, so multiply latency is 3 cycles accept-to-out_valid. Divide is unchanged.
- Undefined: multiply is iterative, XLEN+2 cycles, with no hardware multiplier inferred.

Decomposition:
- Add to xgriscv_defines.v:
  - MDU op encodings (`MDU_MUL` .. `MDU_REMU`).
  - FSM state encodings (`MDU_IDLE`, `MDU_CALC`, `MDU_FIX`, `MDU_DONE`).
- One sub-module: xgriscv_mdu_divstep. It is a combinational single restoring-division step (partial remainder, quotient shift-in, dividend bit in; new remainder and quotient out), reused by the CALC datapath.
- The FSM, counter, and sign fix stay in xgriscv_mdu.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3) with out_valid 34 cycles after accept. REM of the same -> 0xFFFFFFFF (-1).
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MUL of the same -> 0x00000001. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REMU -> 5, both 1 cycle after accept. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 and REM -> 0, 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. result and out_tag stay stable and in_ready=0. Releasing out_ready completes the handshake, and in_ready=1 the next cycle.
- flush at cycle 10 of a DIV with in_valid=1 in the same cycle -> IDLE next cycle, no out_valid, request not accepted. Re-present the request -> normal completion with the correct tag.
- reset low for 1 cycle during CALC -> out_valid=0, busy=0, in_ready=1 the cycle after reset releases. With MDU_FAST_MUL_EN defined, MUL 3x4 -> 12 in 3 cycles.
